// File: rtl/ex_div_iter_pkg.sv
// Shared definitions for the iterative execute-stage divider:
// FSM state encodings, ready/start levels and the divide aluop codes.
package ex_div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring-division step: shift the working register left by
// one, trial-subtract the divisor from the upper half and shift in the
// resulting quotient bit. Purely combinational so a radix-4 variant can
// chain two of these.
module ex_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] work_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] work_o,
    output logic              q_bit_o
);

    logic [2*DATA_W+1:0] shifted;
    logic [DATA_W+1:0]   upper;
    logic [DATA_W+1:0]   diff;

    // Shift, trial-subtract, keep the difference when it did not borrow.
    always_comb begin
        shifted = {work_i, 1'b0};
        upper   = shifted[2*DATA_W+1:DATA_W];
        diff    = upper - {2'b00, divisor_i};
        q_bit_o = ~diff[DATA_W+1];
        if (q_bit_o) begin
            work_o = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
        end else begin
            work_o = shifted[2*DATA_W:0];
        end
    end

endmodule

// File: rtl/ex_div_iter.sv
// Multi-cycle iterative divider (DIV/DIVU) for the execute stage.
// One quotient bit per clock on magnitudes, sign fix-up on the final step.
// result_o = {remainder, quotient}, valid while ready_o is high.
// Optional build macro EX_DIV_EARLY_EXIT_EN: skip the dividend's leading
// zeros so small dividends finish in fewer cycles (same results).
module ex_div_iter
    import ex_div_iter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t          state_reg;
    logic [2*DATA_W:0]   work_reg;
    logic [DATA_W-1:0]   divisor_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                q_neg_reg;
    logic                r_neg_reg;
    logic                signed_reg;
    logic [2*DATA_W-1:0] result_reg;
    logic                ready_reg;

    logic [DATA_W-1:0]   dividend_mag;
    logic [DATA_W-1:0]   divisor_mag;
    logic [2*DATA_W:0]   init_work;
    logic [CNT_W-1:0]    init_cnt;
    logic [2*DATA_W:0]   step_work;
    logic                step_q;
    logic [DATA_W-1:0]   quot_raw;
    logic [DATA_W-1:0]   rem_raw;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Operand magnitudes; DIVU operands are taken as-is.
    assign dividend_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

`ifdef EX_DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] lead_zeros;

    // Leading-zero count of the dividend magnitude, capped at DATA_W-1 so a
    // zero dividend still runs one step.
    always_comb begin
        lead_zeros = CNT_W'(DATA_W - 1);
        for (int i = 0; i < DATA_W; i++) begin
            if (dividend_mag[i]) begin
                lead_zeros = CNT_W'(DATA_W - 1 - i);
            end
        end
    end

    assign init_work = {{(DATA_W+1){1'b0}}, dividend_mag << lead_zeros};
    assign init_cnt  = lead_zeros;
`else
    assign init_work = {{(DATA_W+1){1'b0}}, dividend_mag};
    assign init_cnt  = '0;
`endif

    ex_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .work_i    (work_reg),
        .divisor_i (divisor_reg),
        .work_o    (step_work),
        .q_bit_o   (step_q)
    );

    // Final-step values: raw magnitudes from the step, then sign fix-up.
    assign quot_raw = {step_work[DATA_W-1:1], step_q};
    assign rem_raw  = step_work[2*DATA_W-1:DATA_W];
    assign quot_fix = (signed_reg && q_neg_reg) ? -quot_raw : quot_raw;
    assign rem_fix  = (signed_reg && r_neg_reg) ? -rem_raw  : rem_raw;

    // Divider FSM: accept, iterate, publish and hold the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= DivFree;
            work_reg    <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            signed_reg  <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DivResultNotReady;
        end else begin
            case (state_reg)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (divisor_i == '0) begin
                            state_reg <= DivByZero;
                        end else begin
                            state_reg   <= DivOn;
                            work_reg    <= init_work;
                            divisor_reg <= divisor_mag;
                            q_neg_reg   <= dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
                            r_neg_reg   <= dividend_i[DATA_W-1];
                            signed_reg  <= signed_i;
                            cnt_reg     <= init_cnt;
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state_reg <= DivFree;
                    end else begin
                        state_reg  <= DivEnd;
                        result_reg <= '0;
                        ready_reg  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state_reg <= DivFree;
                    end else begin
                        work_reg <= step_work;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                            result_reg <= {rem_fix, quot_fix};
                            ready_reg  <= DivResultReady;
                            state_reg  <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    if (annul_i || start_i == DivStop) begin
                        state_reg  <= DivFree;
                        result_reg <= '0;
                        ready_reg  <= DivResultNotReady;
                    end
                end
                default: begin
                    state_reg <= DivFree;
                end
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_ex_div_iter.sv
// Self-checking bench for ex_div_iter (DATA_W = 32). Expected quotient,
// remainder and completion latency come from plain arithmetic on the
// operands; a negedge checker compares ready_o/result_o every cycle.
// Honours EX_DIV_EARLY_EXIT_EN for the expected latency.
module tb_ex_div_iter;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

`ifdef EX_DIV_EARLY_EXIT_EN
    localparam int LAT_7_2 = 3;
    localparam int LAT_5_1 = 3;
    localparam int LAT_0_3 = 1;
`else
    localparam int LAT_7_2 = 32;
    localparam int LAT_5_1 = 32;
    localparam int LAT_0_3 = 32;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           signed_i = 1'b0;
    logic [W-1:0]   dividend_i = '0;
    logic [W-1:0]   divisor_i = '0;
    logic           start_i = 1'b0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic           chk_en = 1'b0;
    logic           exp_ready = 1'b0;
    logic [2*W-1:0] exp_result = '0;

    ex_div_iter #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o)
    );

    always #5 clk = ~clk;

    // Reference quotient/remainder from the language's own division.
    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb, q, r;
        if (b == '0) return '0;
        if (!s) return {a % b, a / b};
        sa = a;
        sb = b;
        if (a == MIN_NEG && b == '1) return {{W{1'b0}}, a};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Leading zeros of the dividend magnitude, capped at W-1.
    function automatic int mag_lz(input logic s, input logic [W-1:0] a);
        logic [W-1:0] mag;
        int lz;
        mag = (s && a[W-1]) ? -a : a;
        lz = 0;
        while (lz < W - 1 && mag[W-1-lz] == 1'b0) lz++;
        return lz;
    endfunction

    // Edges from acceptance until ready_o.
    function automatic int ref_lat(input logic [W-1:0] b, input int lz);
        if (b == '0) return 1;
`ifdef EX_DIV_EARLY_EXIT_EN
        return W - lz;
`else
        return (lz >= 0) ? W : 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h @%0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison of outputs against the model's expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL ready_o: got %b want %b @%0t", ready_o, exp_ready, $time);
            end
            if (exp_ready || !rst) begin
                n_tests++;
                if (result_o !== exp_result) begin
                    n_fail++;
                    $display("FAIL result_o: got %h want %h @%0t", result_o, exp_result, $time);
                end
            end
        end
    end

    // One full request: issue, optional annul at ON edge annul_at, hold,
    // then drop start (or kill in END with end_kill).
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int annul_at, input int hold, input logic end_kill,
                          output int lat_seen, output logic [2*W-1:0] res_seen);
        int lat;
        int lz;
        logic aborted;
        lz = mag_lz(s, a);
        lat = ref_lat(b, lz);
        aborted = 1'b0;
        lat_seen = -1;
        res_seen = '0;
        @(negedge clk);
        signed_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= lat && !aborted; k++) begin
            @(negedge clk);
            dividend_i = $urandom; divisor_i = $urandom; signed_i = 1'($urandom);
            if (k == annul_at) annul_i = 1'b1;
            @(posedge clk);
            if (k == annul_at) begin
                aborted = 1'b1;
            end else if (k == lat) begin
                exp_ready = 1'b1;
                exp_result = ref_div(s, a, b);
            end
            #1;
            if (ready_o === 1'b1 && lat_seen < 0) lat_seen = k;
        end
        if (aborted) begin
            @(posedge clk);
            @(negedge clk);
            annul_i = 1'b0; start_i = 1'b0;
            @(posedge clk);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                dividend_i = $urandom; divisor_i = $urandom;
                @(posedge clk);
            end
            #1 res_seen = result_o;
            @(negedge clk);
            if (end_kill) annul_i = 1'b1;
            else start_i = 1'b0;
            @(posedge clk);
            exp_ready = 1'b0;
            exp_result = '0;
            #1;
            if (!end_kill) check("drop_clear", result_o, '0);
            @(negedge clk);
            annul_i = 1'b0; start_i = 1'b0;
        end
        $display("[TB] op s=%0b a=%h b=%h lz=%0d lat=%0d annul=%0d kill=%0b seen=%0d res=%h",
                 s, a, b, lz, lat, annul_at, end_kill, lat_seen, res_seen);
    endtask

    // Assert the asynchronous reset at_edge edges after acceptance.
    task automatic reset_during(input logic [W-1:0] a, input logic [W-1:0] b, input int at_edge);
        int lat;
        lat = ref_lat(b, mag_lz(1'b0, a));
        @(negedge clk);
        signed_i = 1'b0; dividend_i = a; divisor_i = b; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= at_edge; k++) begin
            @(posedge clk);
            if (k == lat) begin
                exp_ready = 1'b1;
                exp_result = ref_div(1'b0, a, b);
            end
        end
        #2 rst = 1'b0;
        exp_ready = 1'b0;
        exp_result = '0;
        #1;
        check("async_rst_ready", ready_o, '0);
        check("async_rst_result", result_o, '0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        $display("[TB] reset a=%h b=%h at edge %0d", a, b, at_edge);
    endtask

    function automatic logic [W-1:0] pick(input int mode);
        logic [W-1:0] v;
        v = $urandom;
        case (mode)
            0: return v;
            1: return v & 32'hFF;
            2: case ($urandom % 4)
                   0: return MIN_NEG;
                   1: return MAX_POS;
                   2: return '1;
                   default: return 32'h1;
               endcase
            default: return v >> ($urandom % W);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_seen;
        logic [2*W-1:0] res;
        logic s;
        logic [W-1:0] a, b;
        int an;

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready_o, '0);
        check("rst_result", result_o, '0);
        @(negedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;

        run_op(1'b0, 32'd7, 32'd2, 0, 2, 1'b0, lat_seen, res);
        check("lat_7_2", lat_seen, LAT_7_2);
        check("res_7_2", res, {32'h1, 32'h3});

        run_op(1'b1, -32'sd7, 32'd2, 0, 1, 1'b0, lat_seen, res);
        check("res_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});

        run_op(1'b1, 32'd7, -32'sd2, 0, 0, 1'b0, lat_seen, res);
        check("res_7_m2", res, {32'h1, 32'hFFFFFFFD});

        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, lat_seen, res);
        check("res_min_m1", res, {32'h0, 32'h80000000});

        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 0, 0, 1'b0, lat_seen, res);
        check("res_max_1", res, {32'h0, 32'hFFFFFFFF});

        run_op(1'b1, 32'h12345678, 32'd0, 0, 1, 1'b0, lat_seen, res);
        check("lat_div0", lat_seen, 1);
        check("res_div0", res, '0);

        run_op(1'b0, 32'hF0000000, 32'd3, 10, 0, 1'b0, lat_seen, res);
        check("annul_no_ready", lat_seen, -1);

        run_op(1'b0, 32'd100, 32'd7, 0, 0, 1'b0, lat_seen, res);
        check("res_100_7", res, {32'd2, 32'd14});

        run_op(1'b0, 32'd5, 32'd1, 0, 0, 1'b0, lat_seen, res);
        check("lat_5_1", lat_seen, LAT_5_1);
        check("res_5_1", res, {32'd0, 32'd5});

        run_op(1'b0, 32'd0, 32'd3, 0, 0, 1'b0, lat_seen, res);
        check("lat_0_3", lat_seen, LAT_0_3);
        check("res_0_3", res, '0);

        run_op(1'b1, 32'd50, 32'd6, 0, 1, 1'b1, lat_seen, res);
        check("res_50_6", res, {32'd2, 32'd8});

        reset_during(32'hF0000000, 32'd3, 10);
        reset_during(32'd1000, 32'd9, LAT_7_2 + 2);

        for (int i = 0; i < 600; i++) begin
            s = 1'($urandom);
            a = pick($urandom % 4);
            b = ($urandom % 16 == 0) ? '0 : pick($urandom % 4);
            an = ($urandom % 8 == 0) ? $urandom_range(1, ref_lat(b, mag_lz(s, a))) : 0;
            run_op(s, a, b, an, $urandom % 3, ($urandom % 8 == 0), lat_seen, res);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_iter.md
Name: ex_div_iter

Overview:
- Parametrised, multi-cycle iterative divider in the execute stage, radix-2, one quotient bit per clock.
- Serves DIV/DIVU; width is generalised to DATA_W.
- Sits beside the single-cycle logic/shift datapath.
- EX control holds start_i high and stalls the pipeline until ready_o; the result goes to HI (remainder) and LO (quotient).

Parameters:
- DATA_W, 32, operand/quotient/remainder width; any value ≥ 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst == 0.
- signed_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
- dividend_i  in  DATA_W  dividend; sampled at acceptance.
- divisor_i  in  DATA_W  divisor; sampled at acceptance.
- start_i  in  1  request; level, held high by EX until ready_o is seen.
- annul_i  in  1  flush/exception kill; aborts any operation in flight.
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o == 1.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst == 0, asynchronous):
  - state = IDLE; result_o = 0; ready_o = 0; counter and internal registers = 0.
- State machine: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_i == 1 and annul_i == 0 → accepting edge E0.
  - If divisor_i == 0: go to DIVZERO.
  - Otherwise: go to ON. Latch |dividend| and |divisor| (absolute value only when signed_i == 1). Latch the quotient sign (dividend MSB ^ divisor MSB), the remainder sign (dividend MSB) and signed_i. Clear the counter.
  - start_i == 0 or annul_i == 1 → remain in IDLE.
- DIVZERO:
  - Next edge: go to END with result_o = 0.
  - ready_o = 1 one edge after E0.
- ON:
  - Each edge performs one step on a (2*DATA_W+1)-bit working register: shift left 1, trial-subtract the divisor from the upper half. If non-negative, keep the difference and set the quotient LSB to 1; else keep the shifted value and set the quotient LSB to 0.
  - Counter increments each step.
  - The edge that performs step DATA_W (counter == DATA_W-1) also:
    - applies sign correction: two's-complement negate the quotient if the quotient sign is set, and the remainder if the remainder sign is set, signed mode only;
    - registers result_o;
    - sets ready_o = 1;
    - goes to END.
  - ready_o therefore rises at the DATA_W-th edge after E0.
  - annul_i == 1 on any edge in ON → IDLE; ready_o stays 0 and result_o is unchanged.
- END:
  - Hold result_o and ready_o = 1 while start_i == 1.
  - start_i == 0 → IDLE next edge; ready_o = 0 and result_o = 0.
  - annul_i == 1 → IDLE with ready_o = 0.
- Boundary cases:
  - Signed most-negative / -1 → quotient = most-negative (wrapped), remainder 0. No trap.
  - Operands changing after E0 have no effect.
  - start_i and annul_i both high in IDLE → not accepted.
  - Reset mid-ON → immediate return to IDLE.
  - Back-to-back operations: one IDLE cycle between operations is mandatory.

Optional Feature:
- Macro: EX_DIV_EARLY_EXIT_EN.
- Defined:
  - At E0, the unsigned dividend magnitude is pre-shifted left by its leading-zero count L (from a combinational priority encoder), and the counter starts at L.
  - ON runs DATA_W−L steps, and ready_o rises at edge max(DATA_W−L, 1) after E0.
  - Results are identical to the non-early-exit build.
  - A zero dividend with a non-zero divisor completes in 1 step with result 0.
- Undefined: a fixed DATA_W steps for every operation.

Decomposition:
- Shared defines/package:
  - state encodings (DivFree, DivByZero, DivOn, DivEnd);
  - DivResultReady / DivResultNotReady, DivStart / DivStop;
  - aluop codes EXE_DIV_OP / EXE_DIVU_OP, already in the shared aluop set.
- One sub-module, ex_div_step: a combinational single subtract-shift step (working register + divisor → next working register + quotient bit), reusable for a radix-4 variant.

Test Plan:
- Unsigned 7 / 2, DATA_W = 32 → ready_o at edge 32 after E0; result_o = {32'h1, 32'h3}; ready_o falls one edge after start_i drops.
- Signed −7 / 2 → quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Signed 7 / −2 → quotient 32'hFFFFFFFD, remainder 32'h1.
- Signed 32'h80000000 / 32'hFFFFFFFF → quotient 32'h80000000, remainder 0. Unsigned 32'hFFFFFFFF / 1 → quotient 32'hFFFFFFFF, remainder 0.
- Divisor 0, any dividend → ready_o one edge after E0, result_o = 0.
- annul_i pulsed at edge 10 of ON → IDLE, ready_o never rises. A new 100 / 7 issued afterwards → {2, 14}. rst driven low mid-ON → outputs 0 immediately, without waiting for a clock edge.
- With EX_DIV_EARLY_EXIT_EN: 5 / 1 (L = 29) → ready_o at edge 3, result {0, 5}. 0 / 3 → ready_o at edge 1, result 0. Random 1000-vector signed/unsigned comparison against the non-early build.
